// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the controller and the painter blocks.
// Defaults describe the standard 640x480 @ 60 Hz mode with a 25 MHz pixel clock.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 800
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 525

    // First and last counter values during which the sync pulse is active.
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;                // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;          // 751
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;                // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;          // 491

    // Coordinate width; wide enough for any counter value up to 1023.
    localparam int CNT_W = 10;

    // Inclusive window test on a coordinate.
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/counter_vga.sv
// Mod-N up counter with enable. wrap is high while the count sits at N-1,
// so "en && wrap" marks the cycle on which the counter returns to zero.
module counter_vga #(
    parameter int N     = 800,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_reg;

    assign wrap  = (count_reg == WIDTH'(N - 1));
    assign count = count_reg;

    // Advance on enable, returning to zero after N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= wrap ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/controller_vga.sv
// VGA timing generator. clk is divided by two to form the pixel clock; the
// horizontal and vertical counters step once per pixel tick and drive x/y
// directly. Sync, blank and colour are registered from the pre-increment
// counters, so they trail x/y by exactly one pixel tick.
module controller_vga #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_start
);

    import vga_pkg::*;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_W  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_W  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic             div_reg;
    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             visible;
    logic             hsync_reg;
    logic             vsync_reg;
    logic             blank_reg;
    logic             frame_start_reg;
    logic [23:0]      colour_in;
    logic [23:0]      rgb_q;

    // Pixel tick lands on the clk edge where div falls 1->0, so registered
    // outputs change while vga_clk is low and are stable at its rising edge.
    assign tick    = div_reg;
    assign vga_clk = div_reg;

    // Divide clk by two to form the pixel clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= 1'b0;
        end else begin
            div_reg <= ~div_reg;
        end
    end

    counter_vga #(.N(H_TOTAL), .WIDTH(CNT_W)) u_h_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    counter_vga #(.N(V_TOTAL), .WIDTH(CNT_W)) u_v_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick && h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    assign x       = h_cnt;
    assign y       = v_cnt;
    assign visible = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);

    // Sync and blank sampled from the current pixel on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            blank_reg <= 1'b0;
        end else if (tick) begin
            hsync_reg <= ~in_window(h_cnt, HS_START, HS_END);
            vsync_reg <= ~in_window(v_cnt, VS_START, VS_END);
            blank_reg <= visible;
        end
    end

    // Frame start: one clk wide because tick never holds for two clks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= tick && h_wrap && v_wrap;
        end
    end

    // Colour channels: capture painter colour when visible, black otherwise.
    assign colour_in = {red_in, green_in, blue_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_colour
            logic [7:0] chan_reg;

            // One register per colour channel, gated by visibility.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chan_reg <= 8'd0;
                end else if (tick) begin
                    chan_reg <= visible ? colour_in[gi*8 +: 8] : 8'd0;
                end
            end

            assign rgb_q[gi*8 +: 8] = chan_reg;
        end
    endgenerate

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign blank_n     = blank_reg;
    assign sync_n      = 1'b0;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_controller_vga.sv
// Self-checking bench for controller_vga. Two instances share clk/rst_n: one
// with the default 640x480 timing (constant colour) and one shrunk so whole
// frames fit in a short run (random colour). Expected outputs come from a
// model that derives everything from the number of clk edges since reset.
module tb_controller_vga;

    // Reduced timing for the small instance: 90 x 50 pixels per frame.
    localparam int SHV = 64, SHF = 8, SHS = 12, SHB = 6;
    localparam int SVV = 40, SVF = 3, SVS = 2, SVB = 5;

    typedef struct packed {
        logic        vga_clk;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hsync;
        logic        vsync;
        logic        blank_n;
        logic        sync_n;
        logic [23:0] rgb;
        logic        frame_start;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0] red_s = 8'd0, green_s = 8'd0, blue_s = 8'd0;
    logic [7:0] red_b = 8'h90, green_b = 8'h0C, blue_b = 8'h3F;

    logic [9:0] x_s, y_s, x_b, y_b;
    logic vga_clk_s, hsync_s, vsync_s, blank_n_s, sync_n_s, frame_start_s;
    logic vga_clk_b, hsync_b, vsync_b, blank_n_b, sync_n_b, frame_start_b;
    logic [7:0] vga_r_s, vga_g_s, vga_b_s, vga_r_b, vga_g_b, vga_b_b;

    logic [7:0] tab_r [256];
    logic [7:0] tab_g [256];
    logic [7:0] tab_b [256];

    int     errors = 0;
    int     checks = 0;
    longint k = 0;
    obs_t   exp_s, exp_b, obs_s, obs_b;

    always #5 clk = ~clk;

    controller_vga #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_small (
        .clk(clk), .rst_n(rst_n),
        .red_in(red_s), .green_in(green_s), .blue_in(blue_s),
        .x(x_s), .y(y_s), .vga_clk(vga_clk_s),
        .hsync(hsync_s), .vsync(vsync_s), .blank_n(blank_n_s), .sync_n(sync_n_s),
        .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s),
        .frame_start(frame_start_s)
    );

    controller_vga dut_big (
        .clk(clk), .rst_n(rst_n),
        .red_in(red_b), .green_in(green_b), .blue_in(blue_b),
        .x(x_b), .y(y_b), .vga_clk(vga_clk_b),
        .hsync(hsync_b), .vsync(vsync_b), .blank_n(blank_n_b), .sync_n(sync_n_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .frame_start(frame_start_b)
    );

    assign obs_s = {vga_clk_s, x_s, y_s, hsync_s, vsync_s, blank_n_s, sync_n_s,
                    vga_r_s, vga_g_s, vga_b_s, frame_start_s};
    assign obs_b = {vga_clk_b, x_b, y_b, hsync_b, vsync_b, blank_n_b, sync_n_b,
                    vga_r_b, vga_g_b, vga_b_b, frame_start_b};

    // Expected outputs after kk clk edges since reset release. Each pair of
    // edges is one pixel; the registered outputs describe the previous pixel.
    function automatic obs_t model(input longint kk, input bit is_small);
        obs_t   m;
        int     hv, hf, hs, hb, vv, vf, vs, vb, ht, vt;
        longint fr, t, p, q;
        int     qx, qy;
        bit     vis;
        if (is_small) begin
            hv = SHV; hf = SHF; hs = SHS; hb = SHB; vv = SVV; vf = SVF; vs = SVS; vb = SVB;
        end else begin
            hv = 640; hf = 16; hs = 96; hb = 48; vv = 480; vf = 10; vs = 2; vb = 33;
        end
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        fr = longint'(ht) * vt;
        t  = kk / 2;
        p  = t % fr;
        m.vga_clk = (kk % 2) == 1;
        m.x       = 10'(p % ht);
        m.y       = 10'(p / ht);
        m.sync_n  = 1'b0;
        if (t == 0) begin
            m.hsync   = 1'b1;
            m.vsync   = 1'b1;
            m.blank_n = 1'b0;
            m.rgb     = 24'h0;
        end else begin
            q   = (t - 1) % fr;
            qx  = int'(q % ht);
            qy  = int'(q / ht);
            vis = (qx < hv) && (qy < vv);
            m.hsync   = !(qx >= hv + hf && qx < hv + hf + hs);
            m.vsync   = !(qy >= vv + vf && qy < vv + vf + vs);
            m.blank_n = vis;
            if (!vis)          m.rgb = 24'h0;
            else if (is_small) m.rgb = {tab_r[q % 256], tab_g[q % 256], tab_b[q % 256]};
            else               m.rgb = 24'h900C3F;
        end
        m.frame_start = ((kk % 2) == 0) && (t > 0) && (p == 0);
        return m;
    endfunction

    // Painter stand-in for the small instance: colour depends on the pixel index.
    task automatic drive_colour();
        longint p;
        p = (k / 2) % (longint'(SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB));
        red_s   = tab_r[p % 256];
        green_s = tab_g[p % 256];
        blue_s  = tab_b[p % 256];
    endtask

    // Advance one clk and refresh the expected outputs of both instances.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
        drive_colour();
        exp_s = model(k, 1'b1);
        exp_b = model(k, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            k = 0;
            exp_s = model(0, 1'b1);
            exp_b = model(0, 1'b0);
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL reset_small got=%h exp=%h", obs_s, exp_s);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL reset_big got=%h exp=%h", obs_b, exp_b);
            end
        end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_reset_release();
        rst_n = 1'b1;
        k = 0;
        drive_colour();
        for (int i = 0; i < 1400; i++) begin
            step();
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                if (errors < 30) $display("FAIL release_small k=%0d got=%h exp=%h", k, obs_s, exp_s);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                if (errors < 30) $display("FAIL release_big k=%0d got=%h exp=%h", k, obs_b, exp_b);
            end
            if (k == 2) begin
                checks++;
                if ({vga_r_b, vga_g_b, vga_b_b} !== 24'h900C3F) begin
                    errors++;
                    $display("FAIL colour_first_pixel got=%h exp=900c3f", {vga_r_b, vga_g_b, vga_b_b});
                end
            end
            if (k == 2 * 641) begin
                checks++;
                if ({vga_r_b, vga_g_b, vga_b_b} !== 24'h0 || blank_n_b !== 1'b0) begin
                    errors++;
                    $display("FAIL colour_x640 got=%h blank=%b exp=000000 blank=0",
                             {vga_r_b, vga_g_b, vga_b_b}, blank_n_b);
                end
            end
        end
        $display("test_reset_release: done, errors so far %0d", errors);
    endtask

    task automatic test_line_timing();
        longint fall1 = -1, fall2 = -1, rise = -1, brise = -1, bfall = -1;
        logic   prev_h, prev_bl;
        prev_h  = hsync_b;
        prev_bl = blank_n_b;
        for (int i = 0; i < 4800; i++) begin
            step();
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                if (errors < 30) $display("FAIL line_small k=%0d got=%h exp=%h", k, obs_s, exp_s);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                if (errors < 30) $display("FAIL line_big k=%0d got=%h exp=%h", k, obs_b, exp_b);
            end
            if (prev_h && !hsync_b) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!prev_h && hsync_b && fall1 >= 0 && rise < 0) rise = k;
            if (!prev_bl && blank_n_b && brise < 0) brise = k;
            if (prev_bl && !blank_n_b && brise >= 0 && bfall < 0) bfall = k;
            prev_h  = hsync_b;
            prev_bl = blank_n_b;
        end
        checks++;
        if (fall2 - fall1 != 1600) begin
            errors++;
            $display("FAIL line_period got=%0d exp=1600", fall2 - fall1);
        end
        checks++;
        if (rise - fall1 != 192) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=192", rise - fall1);
        end
        checks++;
        if (bfall - brise != 1280) begin
            errors++;
            $display("FAIL blank_width got=%0d exp=1280", bfall - brise);
        end
        $display("test_line_timing: period=%0d hsync_low=%0d blank_high=%0d",
                 fall2 - fall1, rise - fall1, bfall - brise);
    endtask

    task automatic test_frame_timing();
        longint fs_k[$];
        longint vfall = -1, vrise = -1;
        int     fs_cycles = 0;
        logic   prev_v;
        prev_v = vsync_s;
        while (k < 18500) begin
            step();
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                if (errors < 30) $display("FAIL frame_small k=%0d got=%h exp=%h", k, obs_s, exp_s);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                if (errors < 30) $display("FAIL frame_big k=%0d got=%h exp=%h", k, obs_b, exp_b);
            end
            if (frame_start_s) begin
                fs_cycles++;
                fs_k.push_back(k);
            end
            if (prev_v && !vsync_s && vfall < 0) vfall = k;
            if (!prev_v && vsync_s && vfall >= 0 && vrise < 0) vrise = k;
            prev_v = vsync_s;
            if (k == 9000) begin
                checks++;
                if (x_s !== 10'd0 || y_s !== 10'd0 || frame_start_s !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_frame got x=%0d y=%0d fs=%b exp x=0 y=0 fs=1",
                             x_s, y_s, frame_start_s);
                end
            end
            if (k == 2 * 11 * 800) begin
                checks++;
                if (x_b !== 10'd0 || y_b !== 10'd11) begin
                    errors++;
                    $display("FAIL wrap_line got x=%0d y=%0d exp x=0 y=11", x_b, y_b);
                end
            end
        end
        checks++;
        if (fs_k.size() != 2 || fs_cycles != 2) begin
            errors++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cycles);
        end else begin
            checks++;
            if (fs_k[1] - fs_k[0] != 9000) begin
                errors++;
                $display("FAIL frame_period got=%0d exp=9000", fs_k[1] - fs_k[0]);
            end
        end
        checks++;
        if (vrise - vfall != 2 * 2 * (SHV + SHF + SHS + SHB)) begin
            errors++;
            $display("FAIL vsync_width got=%0d exp=%0d", vrise - vfall,
                     2 * 2 * (SHV + SHF + SHS + SHB));
        end
        $display("test_frame_timing: frame_starts=%0d vsync_low=%0d", fs_cycles, vrise - vfall);
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (!(exp_s.x == 10'd32 && exp_s.y == 10'd20) && guard < 10000) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 10000) begin
            errors++;
            $display("FAIL mid_reset_reach got=timeout exp=position 32,20");
        end
        #2 rst_n = 1'b0;
        #1;
        exp_s = model(0, 1'b1);
        exp_b = model(0, 1'b0);
        checks++;
        if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL mid_reset_small got=%h exp=%h", obs_s, exp_s);
        end
        checks++;
        if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL mid_reset_big got=%h exp=%h", obs_b, exp_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs_s !== exp_s || obs_b !== exp_b) begin
            errors++;
            $display("FAIL mid_reset_hold got=%h/%h exp=%h/%h", obs_s, obs_b, exp_s, exp_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        drive_colour();
        $display("test_mid_reset: reset applied, errors so far %0d", errors);
    endtask

    task automatic test_restart();
        int     fs_count = 0;
        longint first_fs = -1;
        for (int i = 0; i < 9100; i++) begin
            step();
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                if (errors < 30) $display("FAIL restart_small k=%0d got=%h exp=%h", k, obs_s, exp_s);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                if (errors < 30) $display("FAIL restart_big k=%0d got=%h exp=%h", k, obs_b, exp_b);
            end
            if (frame_start_s) begin
                fs_count++;
                if (first_fs < 0) first_fs = k;
            end
        end
        checks++;
        if (fs_count != 1 || first_fs != 9000) begin
            errors++;
            $display("FAIL restart_frame_start got count=%0d at=%0d exp count=1 at=9000",
                     fs_count, first_fs);
        end
        $display("test_restart: frame_starts=%0d first at k=%0d", fs_count, first_fs);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tab_r[i] = 8'($urandom);
            tab_g[i] = 8'($urandom);
            tab_b[i] = 8'($urandom);
        end
        test_reset();
        test_reset_release();
        test_line_timing();
        test_frame_timing();
        test_mid_reset();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
